// File: rtl/branch_history_table_pkg.sv
// Shared branch-predictor types: table geometry, snapshot record and the history shift helper.
package branch_history_table_pkg;

  localparam int XLEN        = 32;
  localparam int BHT_IDX_W   = 8;
  localparam int HIST_W      = 3;
  localparam int Q_DEPTH     = 8;
  localparam int Q_PTR_W     = $clog2(Q_DEPTH);
  localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

  typedef logic [HIST_W-1:0] hist_t;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    hist_t                hist;
  } bht_snap_t;

  // Newest outcome enters at the LSB; the loop form also covers a 1-bit history.
  function automatic hist_t hist_shift(input hist_t h, input logic taken);
    hist_t r;
    r[0] = taken;
    for (int i = 1; i < HIST_W; i++) r[i] = h[i-1];
    return r;
  endfunction

endpackage

// File: rtl/branch_history_table_snap_fifo.sv
// In-flight snapshot FIFO: push/pop/flush with count-based full/empty disambiguation.
module bht_snap_fifo
  import branch_history_table_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  bht_snap_t        i_push_data,
  output bht_snap_t        o_head_data,
  output logic [Q_PTR_W:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  bht_snap_t          r_mem [Q_DEPTH];
  logic [Q_PTR_W-1:0] r_head;
  logic [Q_PTR_W-1:0] r_tail;
  logic [Q_PTR_W:0]   r_count;
  logic               w_pop;
  logic               w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (Q_PTR_W+1)'(Q_DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
  assign w_push  = i_push && !i_flush && (!o_full || w_pop);

  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_tail] <= i_push_data;
  end

  assign o_head_data = r_mem[r_head];
  assign o_count     = r_count;

endmodule

// File: rtl/branch_history_table.sv
// Local per-PC branch history table with IF read/bypass and a snapshot FIFO so EX trains
// the PHT with the history seen at prediction time.
module branch_history_table
  import branch_history_table_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic [3:0]      bht_if_out,
  output logic            q_full,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            take_branch,
  output logic [3:0]      bht_ex_out,
  output logic            ex_hist_valid,
  input  logic            flush,
  output logic            order_err
);

  hist_t                r_hist [BHT_ENTRIES];
  logic                 r_order_err;
  logic [BHT_IDX_W-1:0] w_if_idx;
  logic [BHT_IDX_W-1:0] w_ex_idx;
  hist_t                w_ex_next;
  hist_t                w_if_hist;
  bht_snap_t            w_push_snap;
  bht_snap_t            w_head_snap;
  logic [Q_PTR_W:0]     w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_unused;

  assign w_if_idx  = if_pc[2 +: BHT_IDX_W];
  assign w_ex_idx  = ex_pc[2 +: BHT_IDX_W];
  assign w_ex_next = hist_shift(r_hist[w_ex_idx], take_branch);

  // Same-cycle resolve of the fetched index: forward the post-update history.
  assign w_if_hist   = (ex_valid && (w_ex_idx == w_if_idx)) ? w_ex_next : r_hist[w_if_idx];
  assign bht_if_out  = 4'(w_if_hist);
  assign w_push_snap = '{idx: w_if_idx, hist: w_if_hist};
  assign w_pop       = ex_valid && !w_empty;

  bht_snap_fifo u_snap_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (if_valid),
    .i_pop       (ex_valid),
    .i_flush     (flush),
    .i_push_data (w_push_snap),
    .o_head_data (w_head_snap),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign q_full        = w_full;
  assign ex_hist_valid = !w_empty;
  assign bht_ex_out    = w_empty ? 4'b0 : 4'(w_head_snap.hist);
  assign order_err     = r_order_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_hist[i] <= '0;
      r_order_err <= 1'b0;
    end else begin
      if (ex_valid) r_hist[w_ex_idx] <= w_ex_next;
      if (w_pop && (w_head_snap.idx != w_ex_idx)) r_order_err <= 1'b1;
    end
  end

  assign w_unused = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0],
                      ex_pc[XLEN-1:BHT_IDX_W+2], ex_pc[1:0], w_count};

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench: stimulus pushes expected head snapshots into a scoreboard queue,
// a negedge monitor pops and compares whenever EX consumes a branch.
module tb_branch_history_table;
  import branch_history_table_pkg::*;

  logic            clock;
  logic            reset;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [3:0]      bht_if_out;
  logic            q_full;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            take_branch;
  logic [3:0]      bht_ex_out;
  logic            ex_hist_valid;
  logic            flush;
  logic            order_err;

  int    n_vec = 0;
  int    n_err = 0;
  hist_t sb[$];

  branch_history_table dut (
    .clock         (clock),
    .reset         (reset),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .bht_if_out    (bht_if_out),
    .q_full        (q_full),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .take_branch   (take_branch),
    .bht_ex_out    (bht_ex_out),
    .ex_hist_valid (ex_hist_valid),
    .flush         (flush),
    .order_err     (order_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && ex_valid) begin
      n_vec++;
      if (ex_hist_valid !== (sb.size() != 0)) begin
        n_err++;
        $display("FAIL ex_hist_valid: got %b want %b", ex_hist_valid, sb.size() != 0);
      end else if (ex_hist_valid) begin
        hist_t e;
        e = sb.pop_front();
        if (bht_ex_out !== 4'(e)) begin
          n_err++;
          $display("FAIL bht_ex_out: got %b want %b", bht_ex_out, 4'(e));
        end
      end
    end
  end

  task automatic drv(input logic iv, input logic [XLEN-1:0] ipc, input logic ev,
                     input logic [XLEN-1:0] epc, input logic tk, input logic fl);
    if_valid    = iv;
    if_pc       = ipc;
    ex_valid    = ev;
    ex_pc       = epc;
    take_branch = tk;
    flush       = fl;
    #1;
  endtask

  task automatic tick(input logic acc, input hist_t snap, input logic fl);
    @(posedge clock);
    #1;
    if (fl) sb.delete();
    if (acc) sb.push_back(snap);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  int unsigned tr_pc [9] = '{32'h4, 32'h8, 32'h8, 32'hC, 32'hC, 32'h14, 32'h14, 32'h14, 32'h10};
  bit          tr_tk [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
  hist_t       exp_s [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd7, 3'd0, 3'd0};
  logic [3:0]  bypass_exp [3] = '{4'b0001, 4'b0011, 4'b0111};

  initial begin
    reset = 1'b1;
    drv(0, 32'h100, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_if_out", bht_if_out, 4'h0);
    chk("reset_hist_valid", {3'b0, ex_hist_valid}, 4'h0);
    chk("reset_q_full", {3'b0, q_full}, 4'h0);
    chk("reset_order_err", {3'b0, order_err}, 4'h0);

    // Train 0x100 taken three times with an empty FIFO; IF sees bypassed values
    for (int i = 0; i < 3; i++) begin
      drv(0, 32'h100, 1, 32'h100, 1, 0);
      chk("train_bypass", bht_if_out, bypass_exp[i]);
      tick(0, '0, 0);
    end
    drv(0, 32'h100, 0, 0, 0, 0);
    chk("train_read", bht_if_out, 4'b0111);
    chk("train_order_err", {3'b0, order_err}, 4'h0);

    // Give idx 1..5 distinct histories
    for (int i = 0; i < 9; i++) begin
      drv(0, 0, 1, tr_pc[i], tr_tk[i], 0);
      tick(0, '0, 0);
    end

    // Fill the FIFO
    for (int i = 0; i < 8; i++) begin
      drv(1, 32'(i * 4), 0, 0, 0, 0);
      chk("fill_if_out", bht_if_out, 4'(exp_s[i]));
      tick(1, exp_s[i], 0);
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("full_q_full", {3'b0, q_full}, 4'h1);
    drv(1, 32'h20, 0, 0, 0, 0);
    tick(0, '0, 0);
    chk("drop_q_full", {3'b0, q_full}, 4'h1);

    // Drain; first pop carries a push that a full FIFO must accept
    for (int i = 0; i < 8; i++) begin
      drv(i == 0, 32'h20, 1, 32'(i * 4), 0, 0);
      tick(i == 0, '0, 0);
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("drain_q_full", {3'b0, q_full}, 4'h0);
    drv(0, 0, 1, 32'h20, 0, 0);
    tick(0, '0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("drain_hist_valid", {3'b0, ex_hist_valid}, 4'h0);
    chk("drain_order_err", {3'b0, order_err}, 4'h0);

    // Same-cycle bypass on 0x200 with history 010
    drv(0, 0, 1, 32'h200, 1, 0); tick(0, '0, 0);
    drv(0, 0, 1, 32'h200, 0, 0); tick(0, '0, 0);
    drv(1, 32'h200, 1, 32'h200, 1, 0);
    chk("bypass_if_out", bht_if_out, 4'b0101);
    tick(1, 3'b101, 0);
    drv(0, 0, 1, 32'h200, 0, 0);
    tick(0, '0, 0);

    // Flush with a concurrent push and resolve
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h300 + 32'(i * 4), 0, 0, 0, 0);
      tick(1, '0, 0);
    end
    drv(1, 32'h30C, 1, 32'h300, 1, 1);
    tick(0, '0, 1);
    drv(0, 32'h300, 0, 0, 0, 0);
    chk("flush_hist_valid", {3'b0, ex_hist_valid}, 4'h0);
    chk("flush_q_full", {3'b0, q_full}, 4'h0);
    chk("flush_trained", bht_if_out, 4'b0001);
    chk("flush_order_err", {3'b0, order_err}, 4'h0);
    drv(1, 32'h300, 0, 0, 0, 0); tick(1, 3'b001, 0);
    drv(0, 0, 1, 32'h300, 0, 0); tick(0, '0, 0);

    // Out-of-order resolve sets the sticky error
    drv(1, 32'h400, 0, 0, 0, 0); tick(1, '0, 0);
    drv(0, 0, 1, 32'h404, 0, 0); tick(0, '0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("order_err_set", {3'b0, order_err}, 4'h1);
    drv(1, 32'h10, 0, 0, 0, 0); tick(1, '0, 0);
    drv(0, 0, 1, 32'h10, 0, 0); tick(0, '0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("order_err_sticky", {3'b0, order_err}, 4'h1);

    // Mid-stream reset with an entry queued and a push pending
    drv(1, 32'h10, 0, 0, 0, 0); tick(1, '0, 0);
    reset = 1'b1;
    drv(1, 32'h14, 1, 32'h100, 1, 0);
    tick(0, '0, 0);
    sb.delete();
    reset = 1'b0;
    drv(0, 32'h100, 0, 0, 0, 0);
    chk("rst2_if_out", bht_if_out, 4'h0);
    chk("rst2_hist_valid", {3'b0, ex_hist_valid}, 4'h0);
    chk("rst2_order_err", {3'b0, order_err}, 4'h0);
    chk("rst2_q_full", {3'b0, q_full}, 4'h0);
    drv(0, 0, 1, 32'h100, 0, 0); tick(0, '0, 0);
    drv(0, 0, 0, 0, 0, 0);
    tick(0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
- Local per-PC branch history table. It produces the history index consumed by the pattern history table at fetch (bht_if_out) and at execute (bht_ex_out).
- Keeps a FIFO of in-flight branch snapshots. EX therefore trains the PHT with the exact history used at prediction time, not the current table contents.
- Sits between IF (predict) and EX (resolve). Flushed on branch mispredict.

Parameters:
- BHT_IDX_W, 8, PC bits used as index (pc[2 +: BHT_IDX_W]); 2^BHT_IDX_W entries.
- HIST_W, 3, history bits per entry (1..4); outputs zero-extended to 4 bits.
- Q_DEPTH, 8, in-flight snapshot FIFO depth (power of 2, >=2).

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- if_valid  in  1  IF fetches a conditional branch this cycle (push request)
- if_pc  in  XLEN  fetch PC
- bht_if_out  out  4  history for if_pc (combinational)
- q_full  out  1  FIFO full; IF must stall branch fetch
- ex_valid  in  1  a branch resolves in EX this cycle (pop + train)
- ex_pc  in  XLEN  resolving branch PC
- take_branch  in  1  resolved direction
- bht_ex_out  out  4  history snapshot at FIFO head (combinational)
- ex_hist_valid  out  1  FIFO non-empty
- flush  in  1  mispredict squash: discard all snapshots
- order_err  out  1  sticky: head snapshot index != ex_pc index at a pop

Behaviour:
- Reset: all history entries 0, FIFO empty (head=tail=count=0), q_full=0, ex_hist_valid=0, order_err=0. bht_if_out reflects reset table (0). Reset overrides all inputs in the same cycle, including mid-stream.
- Index rules: if_idx = if_pc[2 +: BHT_IDX_W]; ex_idx = ex_pc[2 +: BHT_IDX_W].
- IF read: bht_if_out = {0, hist[if_idx]}. Zero latency.
  - Bypass: if ex_valid and ex_idx==if_idx in the same cycle, bht_if_out returns the post-update value {hist[idx][HIST_W-2:0], take_branch}.
  - HIST_W==1 case: the bypassed value is simply take_branch.
- Push: if_valid && (!q_full || pop_this_cycle) && !flush.
  - Writes {if_idx, bht_if_out[HIST_W-1:0]} at tail; tail++ mod Q_DEPTH.
  - A push while full without a simultaneous pop is dropped.
- Pop: ex_valid && count!=0.
  - head++ mod Q_DEPTH.
  - If stored idx != ex_idx, set order_err (stays set until reset).
  - ex_valid with empty FIFO: no pop, no error; the history update still occurs.
- Train: on ex_valid (regardless of FIFO state), hist[ex_idx] <= {hist[ex_idx][HIST_W-2:0], take_branch}. Shift left, newest bit in LSB.
- bht_ex_out = {0, head snapshot hist} when count!=0, else 0.
- count:
  - +1 on push only, -1 on pop only, unchanged on both.
  - q_full = (count==Q_DEPTH), registered from count.
- Flush:
  - Next cycle: head=tail=count=0.
  - A same-cycle push is discarded.
  - A same-cycle ex_valid still trains the table; its order check is still performed.
  - Flush does not modify the history table.
- Wrap-around: head/tail are log2(Q_DEPTH)-bit pointers; full/empty are disambiguated by count.
- No X on outputs after reset. All state updates happen on the rising clock edge.

Decomposition:
- Shared package (existing branch-predictor package): BHT_IDX_W, HIST_W, and typedef bht_snap_t {logic [BHT_IDX_W-1:0] idx; logic [HIST_W-1:0] hist;}.
- One sub-module: bht_snap_fifo, a generic push/pop/flush FIFO of bht_snap_t with count/full/empty outputs.
- Table array and bypass logic live in the top module.

Test Plan:
- Reset, then if_pc=0x100 with no activity -> bht_if_out=0, ex_hist_valid=0, q_full=0.
- Resolve pc=0x100 taken three times (ex_valid, FIFO empty) -> hist[0x40] goes 001, 011, 111; IF read of 0x100 then returns 4'b0111; order_err stays 0.
- Push 8 branches (pc 0x0..0x1C), q_full=1; 9th push dropped; 8 pops with matching ex_pc -> bht_ex_out returns the pushed snapshots in order, q_full=0, ex_hist_valid=0.
- Same cycle: if_pc=ex_pc=0x200, hist=010, take_branch=1 -> bht_if_out=4'b0101 and the snapshot pushed =101.
- Push 3 snapshots, then flush together with a push and ex_valid on pc 0x300 -> next cycle count=0, the pushed entry is absent, hist[0xC0] is updated.
- Push pc 0x400, then pop with ex_pc 0x404 -> order_err=1 and stays 1 through later clean pops until reset.
